hsi_byte_coder: RTL and testbench



---
 rtl/hsi_byte_coder_pkg.sv | 21 ++
 rtl/hsi_byte_coder_bit_tmr.sv | 31 +++
 rtl/hsi_byte_coder.sv | 120 ++++++++++++
 tb/tb_hsi_byte_coder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hsi_byte_coder_pkg.sv
// Shared definitions for the HSI byte coder: FSM states, frame geometry, line level
// and the parity helper.
package hsi_byte_coder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;
  localparam logic        LINE_IDLE  = 1'b1;

  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return odd ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/hsi_byte_coder_bit_tmr.sv
// Line-bit timer: counts 0..CLK_DIV-1 while run is high and restarts from 0 when run rises.
module bit_tmr #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  output logic bit_end,
  output logic bit_pre
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] PRE  = 8'(CLK_DIV - 2);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != LAST)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // bit_pre flags the second-to-last cycle so the parent can register a last-cycle pulse.
  assign bit_end = run && (cnt_q == LAST);
  assign bit_pre = run && (cnt_q == PRE);

endmodule

// File: rtl/hsi_byte_coder.sv
// Serialises one byte per frame onto the HSI line: start, 8 data bits LSB first,
// parity, stop. All outputs are registered.
module hsi_byte_coder
  import hsi_byte_coder_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 8,
  parameter bit          PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_en,
  input  logic [7:0] d,
  input  logic       d_rdy,
  output logic       busy,
  output logic       tx,
  output logic       byte_done
);

  state_e     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic       par_q, par_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       byte_done_q, byte_done_d;
  logic       run, bit_end, bit_pre;

  assign run = (state_q != ST_IDLE);

  bit_tmr #(.CLK_DIV(CLK_DIV)) u_bit_tmr (
    .clk     (clk),
    .n_rst   (n_rst),
    .run     (run),
    .bit_end (bit_end),
    .bit_pre (bit_pre)
  );

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    byte_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_en && d_rdy) begin
          sh_d      = d;
          par_d     = parity_bit(d, PARITY_ODD);
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          tx_d      = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = sh_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          sh_d      = sh_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            tx_d    = par_q;
            state_d = ST_PAR;
          end else begin
            tx_d = sh_q[1];
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          tx_d    = LINE_IDLE;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        byte_done_d = bit_pre;
        if (bit_end) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= LINE_IDLE;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_hsi_byte_coder.sv
// Directed bench for hsi_byte_coder: three instances (div 4 odd, div 4 even, div 2 odd)
// driven from one stimulus thread.
module tb_hsi_byte_coder;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [2:0] tx_en_s, d_rdy_s;
  logic [7:0] d_s [3];
  logic busy0, busy1, busy2, tx0, tx1, tx2, bd0, bd1, bd2;
  logic [2:0] busy_s, tx_s, bd_s;
  assign busy_s = {busy2, busy1, busy0};
  assign tx_s   = {tx2, tx1, tx0};
  assign bd_s   = {bd2, bd1, bd0};

  hsi_byte_coder #(.CLK_DIV(4), .PARITY_ODD(1'b1)) u0 (
    .clk(clk), .n_rst(n_rst), .tx_en(tx_en_s[0]), .d(d_s[0]), .d_rdy(d_rdy_s[0]),
    .busy(busy0), .tx(tx0), .byte_done(bd0));
  hsi_byte_coder #(.CLK_DIV(4), .PARITY_ODD(1'b0)) u1 (
    .clk(clk), .n_rst(n_rst), .tx_en(tx_en_s[1]), .d(d_s[1]), .d_rdy(d_rdy_s[1]),
    .busy(busy1), .tx(tx1), .byte_done(bd1));
  hsi_byte_coder #(.CLK_DIV(2), .PARITY_ODD(1'b1)) u2 (
    .clk(clk), .n_rst(n_rst), .tx_en(tx_en_s[2]), .d(d_s[2]), .d_rdy(d_rdy_s[2]),
    .busy(busy2), .tx(tx2), .byte_done(bd2));

  typedef struct {
    int         idx;
    int         div;
    logic [7:0] data;
    logic [10:0] frame;  // bit 0 = first bit on the line (start)
  } vec_t;

  vec_t vecs [7];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic run_frame(input int idx, input int div, input logic [7:0] b,
                           input logic [10:0] fr, input string nm);
    int n, busy_cnt, bd_cnt, bd_at, unstable, idle_bad;
    int first_val [11];
    n = 11 * div;
    busy_cnt = 0; bd_cnt = 0; bd_at = -1; unstable = 0; idle_bad = 0;
    for (int j = 0; j < 11; j++) first_val[j] = -1;
    @(negedge clk);
    d_s[idx] = b; tx_en_s[idx] = 1'b1; d_rdy_s[idx] = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (busy_s[idx]) busy_cnt++;
      if (bd_s[idx]) begin bd_cnt++; bd_at = k; end
      if (k <= n) begin
        if ((k - 1) % div == 0) first_val[(k - 1) / div] = int'(tx_s[idx]);
        else if (int'(tx_s[idx]) != first_val[(k - 1) / div]) unstable++;
      end else if (tx_s[idx] !== 1'b1) idle_bad++;
      if (k == 1) begin d_rdy_s[idx] = 1'b0; d_s[idx] = ~b; end
    end
    for (int j = 0; j < 11; j++)
      chk($sformatf("%s_bit%0d", nm, j), first_val[j], int'(fr[j]));
    chk($sformatf("%s_stable", nm), unstable, 0);
    chk($sformatf("%s_busy_len", nm), busy_cnt, n);
    chk($sformatf("%s_done_cnt", nm), bd_cnt, 1);
    chk($sformatf("%s_done_at", nm), bd_at, n);
    chk($sformatf("%s_idle_after", nm), idle_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hist_tx [700];
    logic hist_bd [700];
    int start_at [10];
    int starts, nxt, bd_total, sp, busy_cnt, rises, bad;
    logic prev;
    logic [7:0] v;

    vecs[0] = '{0, 4, 8'hA5, 11'b11_10100101_0};
    vecs[1] = '{0, 4, 8'h00, 11'b11_00000000_0};
    vecs[2] = '{0, 4, 8'hFF, 11'b11_11111111_0};
    vecs[3] = '{1, 4, 8'h07, 11'b11_00000111_0};
    vecs[4] = '{1, 4, 8'h03, 11'b10_00000011_0};
    vecs[5] = '{2, 2, 8'h80, 11'b10_10000000_0};
    vecs[6] = '{2, 2, 8'h3C, 11'b11_00111100_0};

    n_rst = 1'b0; tx_en_s = '0; d_rdy_s = '0;
    for (int i = 0; i < 3; i++) d_s[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_tx", int'(tx_s), 7);
    chk("rst_busy", int'(busy_s), 0);
    chk("rst_done", int'(bd_s), 0);
    n_rst = 1'b1;

    // IDLE with d_rdy low: line stays idle
    tx_en_s = '1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy_s !== 3'b000 || tx_s !== 3'b111) bad++;
    end
    chk("idle_no_rdy", bad, 0);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].idx, vecs[i].div, vecs[i].data, vecs[i].frame, $sformatf("v%0d", i));

    // Back-to-back: d_rdy held, d updated on each busy rise
    @(negedge clk);
    d_s[0] = 8'h00; d_rdy_s[0] = 1'b1; tx_en_s[0] = 1'b1;
    starts = 0; nxt = 1; prev = 1'b0; bd_total = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      hist_tx[c] = tx_s[0];
      hist_bd[c] = bd_s[0];
      if (bd_s[0]) bd_total++;
      if (busy_s[0] && !prev && starts < 10) begin
        start_at[starts] = c;
        starts++;
        if (nxt < 10) d_s[0] = 8'(nxt);
        nxt++;
        if (starts == 10) d_rdy_s[0] = 1'b0;
      end
      prev = busy_s[0];
    end
    chk("b2b_starts", starts, 10);
    chk("b2b_done_pulses", bd_total, 10);
    for (int i = 1; i < 10; i++) begin
      sp = (i < starts) ? start_at[i] - start_at[i-1] : -1;
      chk($sformatf("b2b_spacing%0d", i), sp, 45);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < starts && start_at[i] + 44 < 700) begin
        for (int j = 0; j < 8; j++) v[j] = hist_tx[start_at[i] + 5 + 4*j];
        chk($sformatf("b2b_byte%0d", i), int'(v), i);
      end else begin
        chk($sformatf("b2b_byte%0d", i), -1, i);
      end
    end

    // tx_en dropped mid-frame
    @(negedge clk);
    d_s[0] = 8'hFF; d_rdy_s[0] = 1'b1; tx_en_s[0] = 1'b1;
    busy_cnt = 0; rises = 0; prev = 1'b0; bd_total = 0; bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy_s[0]) busy_cnt++;
      if (busy_s[0] && !prev) rises++;
      if (bd_s[0]) bd_total++;
      if (c >= 32 && tx_s[0] !== 1'b1) bad++;  // bit7, parity, stop and idle all 1 for 0xFF
      prev = busy_s[0];
      if (c == 9) tx_en_s[0] = 1'b0;
    end
    chk("txen_busy_len", busy_cnt, 44);
    chk("txen_starts", rises, 1);
    chk("txen_done", bd_total, 1);
    chk("txen_tail_high", bad, 0);
    d_rdy_s[0] = 1'b0; tx_en_s[0] = 1'b1;

    // Async reset during DATA bit 3 (d=0x52, bit3=0)
    @(negedge clk);
    d_s[0] = 8'h52; d_rdy_s[0] = 1'b1;
    @(negedge clk);
    d_rdy_s[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("arst_pre_tx", int'(tx_s[0]), 0);
    chk("arst_pre_busy", int'(busy_s[0]), 1);
    #1 n_rst = 1'b0;
    #1;
    chk("arst_tx", int'(tx_s[0]), 1);
    chk("arst_busy", int'(busy_s[0]), 0);
    chk("arst_done", int'(bd_s[0]), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy_s[0] !== 1'b0 || tx_s[0] !== 1'b1 || bd_s[0] !== 1'b0) bad++;
    end
    chk("arst_idle_after", bad, 0);
    run_frame(0, 4, 8'h52, 11'b10_01010010_0, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
